// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the CPU writeback stage and NUM_REQ
// round-robin requesters, with a starvation guard that periodically forces a requester slot.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    input  logic                           cpu_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          cpu_writeReg,
    input  logic [DATA_WIDTH-1:0]          cpu_data,
    output logic                           cpu_stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]          data_writeReg,
    output logic [7:0]                     drop_count
);

    localparam int unsigned PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]      rr_ptr;
    logic [STARVE_W-1:0]   starve_cnt;

    logic                  any_valid;
    logic                  force_req;
    logic                  cpu_win;
    logic                  req_win;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [PTR_W-1:0]      rr_next;

    assign any_valid = |req_valid;
    assign force_req = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && any_valid;
    assign cpu_win   = cpu_writeEnable && !force_req;
    assign req_win   = !cpu_win && any_valid;

    // First valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic found;
        found     = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found         = 1'b1;
                grant_idx     = PTR_W'(idx);
                grant_oh[idx] = 1'b1;
                sel_addr      = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data      = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign req_ready = (!ctrl_reset && req_win) ? grant_oh : '0;
    assign cpu_stall = !ctrl_reset && cpu_writeEnable && !cpu_win;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            rr_ptr           <= '0;
            starve_cnt       <= '0;
            drop_count       <= '0;
        end else begin
            if (cpu_win) begin
                ctrl_writeEnable <= 1'b1;
                ctrl_writeReg    <= cpu_writeReg;
                data_writeReg    <= cpu_data;
            end else if (req_win) begin
                // Register 0 writes are accepted but suppressed at the regfile port.
                ctrl_writeEnable <= (sel_addr != '0);
                ctrl_writeReg    <= sel_addr;
                data_writeReg    <= sel_data;
                rr_ptr           <= rr_next;
                if (sel_addr == '0 && drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else begin
                ctrl_writeEnable <= 1'b0;
            end

            if (cpu_win && any_valid) begin
                if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter with hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;

    logic         clock = 1'b0;
    logic         ctrl_reset;
    logic         cpu_writeEnable;
    logic [4:0]   cpu_writeReg;
    logic [31:0]  cpu_data;
    logic         cpu_stall;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         ctrl_writeEnable;
    logic [4:0]   ctrl_writeReg;
    logic [31:0]  data_writeReg;
    logic [7:0]   drop_count;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(8)
    ) dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .cpu_writeEnable (cpu_writeEnable),
        .cpu_writeReg    (cpu_writeReg),
        .cpu_data        (cpu_data),
        .cpu_stall       (cpu_stall),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .drop_count      (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        cwe;
        logic [4:0]  creg;
        logic [31:0] cdata;
        logic [3:0]  rv;
        logic [19:0] raddr;
        logic        exp_stall;
        logic [3:0]  exp_ready;
        logic        exp_we;
        logic        chk_wd;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    // Requester i carries data A0+i; normal addresses are i+1.
    localparam logic [19:0]  ADDR_NORM = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0]  ADDR_DROP = {5'd4, 5'd3, 5'd0, 5'd1};
    localparam logic [127:0] REQ_DATA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic cwe, input logic [4:0] creg, input logic [31:0] cdata,
                       input logic [3:0] rv, input logic [19:0] raddr, input logic exp_stall,
                       input logic [3:0] exp_ready, input logic exp_we, input logic chk_wd,
                       input logic [4:0] exp_reg, input logic [31:0] exp_data);
        vec_t v;
        v.cwe = cwe; v.creg = creg; v.cdata = cdata; v.rv = rv; v.raddr = raddr;
        v.exp_stall = exp_stall; v.exp_ready = exp_ready; v.exp_we = exp_we;
        v.chk_wd = chk_wd; v.exp_reg = exp_reg; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic cwe, input logic [4:0] creg, input logic [31:0] cdata,
                         input logic [3:0] rv, input logic [19:0] raddr);
        cpu_writeEnable = cwe;
        cpu_writeReg    = creg;
        cpu_data        = cdata;
        req_valid       = rv;
        req_addr        = raddr;
    endtask

    initial begin
        req_data   = REQ_DATA;
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 4'b0000, ADDR_NORM);
        #1;
        check("rst_we", 32'(ctrl_writeEnable), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;

        // CPU only
        add(1, 5'd7, 32'hDEADBEEF, 4'b0000, ADDR_NORM, 0, 4'b0000, 1, 1, 5'd7, 32'hDEADBEEF);
        // Round-robin over four requesters, then a lone requester 3 returns the pointer to 0
        add(0, 5'd0, 32'h0, 4'b1111, ADDR_NORM, 0, 4'b0001, 1, 1, 5'd1, 32'hA0);
        add(0, 5'd0, 32'h0, 4'b1111, ADDR_NORM, 0, 4'b0010, 1, 1, 5'd2, 32'hA1);
        add(0, 5'd0, 32'h0, 4'b1111, ADDR_NORM, 0, 4'b0100, 1, 1, 5'd3, 32'hA2);
        add(0, 5'd0, 32'h0, 4'b1111, ADDR_NORM, 0, 4'b1000, 1, 1, 5'd4, 32'hA3);
        add(0, 5'd0, 32'h0, 4'b1111, ADDR_NORM, 0, 4'b0001, 1, 1, 5'd1, 32'hA0);
        add(0, 5'd0, 32'h0, 4'b1000, ADDR_NORM, 0, 4'b1000, 1, 1, 5'd4, 32'hA3);
        add(0, 5'd0, 32'h0, 4'b0000, ADDR_NORM, 0, 4'b0000, 0, 0, 5'd0, 32'h0);
        // Pointer hold: CPU wins three cycles, pointer stays at 0
        for (int i = 0; i < 3; i++)
            add(1, 5'd9, 32'h99, 4'b0011, ADDR_NORM, 0, 4'b0000, 1, 1, 5'd9, 32'h99);
        add(0, 5'd0, 32'h0, 4'b0011, ADDR_NORM, 0, 4'b0001, 1, 1, 5'd1, 32'hA0);
        add(0, 5'd0, 32'h0, 4'b0011, ADDR_NORM, 0, 4'b0010, 1, 1, 5'd2, 32'hA1);
        add(0, 5'd0, 32'h0, 4'b0000, ADDR_NORM, 0, 4'b0000, 0, 0, 5'd0, 32'h0);
        // Starvation: eight CPU wins, forced requester slot, CPU resumes
        for (int i = 0; i < 8; i++)
            add(1, 5'd5, 32'h55, 4'b0100, ADDR_NORM, 0, 4'b0000, 1, 1, 5'd5, 32'h55);
        add(1, 5'd5, 32'h55, 4'b0100, ADDR_NORM, 1, 4'b0100, 1, 1, 5'd3, 32'hA2);
        add(1, 5'd5, 32'h55, 4'b0000, ADDR_NORM, 0, 4'b0000, 1, 1, 5'd5, 32'h55);
        // CPU write to register 0 passes through
        add(1, 5'd0, 32'h1234, 4'b0000, ADDR_NORM, 0, 4'b0000, 1, 1, 5'd0, 32'h1234);

        foreach (vecs[n]) begin
            @(negedge clock);
            drive(vecs[n].cwe, vecs[n].creg, vecs[n].cdata, vecs[n].rv, vecs[n].raddr);
            #1;
            check($sformatf("v%0d_stall", n), 32'(cpu_stall), 32'(vecs[n].exp_stall));
            check($sformatf("v%0d_ready", n), 32'(req_ready), 32'(vecs[n].exp_ready));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_we", n), 32'(ctrl_writeEnable), 32'(vecs[n].exp_we));
            if (vecs[n].chk_wd) begin
                check($sformatf("v%0d_reg", n), 32'(ctrl_writeReg), 32'(vecs[n].exp_reg));
                check($sformatf("v%0d_data", n), data_writeReg, vecs[n].exp_data);
            end
        end

        // Register 0 drop: pointer is at 3, so scan 3,0,1 reaches requester 1
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 4'b0010, ADDR_DROP);
        #1;
        check("drop_ready", 32'(req_ready), 32'b0010);
        @(posedge clock);
        #1;
        check("drop_we", 32'(ctrl_writeEnable), 32'd0);
        check("drop_cnt1", 32'(drop_count), 32'd1);
        repeat (259) @(posedge clock);
        #1;
        check("drop_sat", 32'(drop_count), 32'd255);
        check("drop_sat_we", 32'(ctrl_writeEnable), 32'd0);

        // Reset asserted mid-cycle with a write already issued and requests pending
        @(negedge clock);
        drive(1'b1, 5'd6, 32'h66, 4'b1111, ADDR_NORM);
        @(posedge clock);
        #1;
        check("pre_rst_we", 32'(ctrl_writeEnable), 32'd1);
        #2;
        ctrl_reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(ctrl_writeEnable), 32'd0);
        check("mid_rst_reg", 32'(ctrl_writeReg), 32'd0);
        check("mid_rst_data", data_writeReg, 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        check("mid_rst_stall", 32'(cpu_stall), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 4'b1111, ADDR_NORM);
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 4'b0000, ADDR_NORM);
        @(posedge clock);
        #1;
        check("post_rst_idle_we", 32'(ctrl_writeEnable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
